// File: rtl/secure_mem_bank.sv
// Password-gated memory bank: rewritable RAM lower half, write-once ROM upper half,
// with consecutive-failure counting and a timed lockout.
module secure_mem_bank #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 4,
  parameter int unsigned       PW_W        = 8,
  parameter logic [PW_W-1:0]   RAM_PW      = 8'hBF,
  parameter logic [PW_W-1:0]   ROM_PW      = 8'h3E,
  parameter int unsigned       MAX_FAIL    = 3,
  parameter int unsigned       LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PW_W-1:0]   password_input,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_input,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic [DATA_W-1:0] data_output,
  output logic              data_valid,
  output logic              auth_fail,
  output logic              op_err,
  output logic              locked
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned FailW  = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int unsigned TimerW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {StOpen, StLocked} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [Depth];
  logic [Depth-1:0]    programmed;
  logic [FailW-1:0]    fail_cnt;
  logic [TimerW-1:0]   timer;

  logic                is_rom;
  logic [PW_W-1:0]     region_pw;
  logic                pw_ok;

  assign is_rom    = addr[ADDR_W-1];
  assign region_pw = is_rom ? ROM_PW : RAM_PW;
  assign pw_ok     = (password_input == region_pw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StOpen;
      data_output <= '0;
      data_valid  <= 1'b0;
      auth_fail   <= 1'b0;
      op_err      <= 1'b0;
      locked      <= 1'b0;
      programmed  <= '0;
      fail_cnt    <= '0;
      timer       <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      data_valid <= 1'b0;
      auth_fail  <= 1'b0;
      op_err     <= 1'b0;
      unique case (state)
        StOpen: begin
          if (write_enable && read_enable) begin
            op_err <= 1'b1;
          end else if (write_enable || read_enable) begin
            if (!pw_ok) begin
              auth_fail <= 1'b1;
              if (fail_cnt == FailW'(MAX_FAIL - 1)) begin
                state    <= StLocked;
                locked   <= 1'b1;
                timer    <= TimerW'(LOCK_CYCLES);
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_cnt + 1'b1;
              end
            end else begin
              fail_cnt <= '0;
              if (write_enable) begin
                // ROM words accept exactly one write between resets
                if (is_rom && programmed[addr]) begin
                  op_err <= 1'b1;
                end else begin
                  mem[addr] <= data_input;
                  if (is_rom) programmed[addr] <= 1'b1;
                end
              end else begin
                data_output <= mem[addr];
                data_valid  <= 1'b1;
              end
            end
          end
        end
        StLocked: begin
          // Leaving on timer==1 keeps locked high for exactly LOCK_CYCLES clocks
          if (timer <= TimerW'(1)) begin
            state  <= StOpen;
            locked <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= StOpen;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_mem_bank.sv
// Self-checking bench for secure_mem_bank: read data is scoreboarded through a queue,
// pulses and lock state are checked inline by each scenario task.
module tb_secure_mem_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] password_input = '0;
  logic [3:0] addr = '0;
  logic [7:0] data_input = '0;
  logic       write_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic [7:0] data_output;
  logic       data_valid;
  logic       auth_fail;
  logic       op_err;
  logic       locked;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  secure_mem_bank dut (
    .clk            (clk),
    .rst            (rst),
    .password_input (password_input),
    .addr           (addr),
    .data_input     (data_input),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .data_output    (data_output),
    .data_valid     (data_valid),
    .auth_fail      (auth_fail),
    .op_err         (op_err),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  // Scoreboard: every data_valid pulse must match the oldest expected read.
  always @(posedge clk) begin
    logic [7:0] exp;
    #1;
    if (data_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL stray_data_valid: got data %h, no read expected", data_output);
      end else begin
        exp = exp_q.pop_front();
        if (data_output !== exp) $display("FAIL read_data: got %h want %h", data_output, exp);
        else passes++;
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] pw,
                       input logic [3:0] a, input logic [7:0] d);
    write_enable   = w;
    read_enable    = r;
    password_input = pw;
    addr           = a;
    data_input     = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic rd_push(input logic [3:0] a, input logic [7:0] pw, input logic [7:0] exp);
    exp_q.push_back(exp);
    drive(1'b0, 1'b1, pw, a, 8'h00);
  endtask

  task automatic drop_missing(input string name);
    checks++;
    if (data_valid !== 1'b1) begin
      $display("FAIL %s_valid: got %b want 1", name, data_valid);
      if (exp_q.size() > 0) exp_q.delete(0);
    end else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({data_output, data_valid, auth_fail, op_err, locked} !== 12'h000)
      $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000",
               data_output, data_valid, auth_fail, op_err, locked);
    else passes++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_auth_fail();
    drive(1'b1, 1'b0, 8'h9A, 4'd2, 8'hEE);
    checks++;
    if (auth_fail !== 1'b1 || op_err !== 1'b0)
      $display("FAIL wrong_pw_write: got auth_fail=%b op_err=%b want 1 0", auth_fail, op_err);
    else passes++;
    rd_push(4'd2, 8'hBF, 8'h00);
    drop_missing("read_after_reject");
    checks++;
    if (auth_fail !== 1'b0) $display("FAIL good_read_no_auth: got %b want 0", auth_fail);
    else passes++;
  endtask

  task automatic test_ram_rw();
    drive(1'b1, 1'b0, 8'hBF, 4'd2, 8'hDD);
    rd_push(4'd2, 8'hBF, 8'hDD);
    drop_missing("ram_read_dd");
    drive(1'b1, 1'b0, 8'hBF, 4'd2, 8'hBB);
    rd_push(4'd2, 8'hBF, 8'hBB);
    drop_missing("ram_read_bb");
    drive(1'b1, 1'b0, 8'hBF, 4'd5, 8'h5A);
    // Held read_enable: one read per cycle, alternating addresses
    rd_push(4'd5, 8'hBF, 8'h5A);
    drop_missing("held_read_0");
    rd_push(4'd2, 8'hBF, 8'hBB);
    drop_missing("held_read_1");
  endtask

  task automatic test_rom();
    drive(1'b1, 1'b0, 8'h3E, 4'd9, 8'hCC);
    rd_push(4'd9, 8'h3E, 8'hCC);
    drop_missing("rom_read");
    drive(1'b0, 1'b1, 8'hBF, 4'd9, 8'h00);
    checks++;
    if (auth_fail !== 1'b1 || data_valid !== 1'b0 || data_output !== 8'hCC)
      $display("FAIL rom_ram_pw: got auth=%b valid=%b data=%h want 1 0 cc",
               auth_fail, data_valid, data_output);
    else passes++;
    drive(1'b1, 1'b0, 8'h3E, 4'd9, 8'hFF);
    checks++;
    if (op_err !== 1'b1 || auth_fail !== 1'b0)
      $display("FAIL rom_rewrite: got op_err=%b auth=%b want 1 0", op_err, auth_fail);
    else passes++;
    rd_push(4'd9, 8'h3E, 8'hCC);
    drop_missing("rom_read_after_rewrite");
  endtask

  task automatic test_lockout();
    bit hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h00, 4'd0, 8'h77);
      checks++;
      if (auth_fail !== 1'b1 || locked !== (i == 2))
        $display("FAIL lock_attempt_%0d: got auth=%b locked=%b want 1 %b",
                 i, auth_fail, locked, (i == 2));
      else passes++;
    end
    drive(1'b0, 1'b1, 8'hBF, 4'd2, 8'h00);
    checks++;
    if (data_valid !== 1'b0 || auth_fail !== 1'b0 || op_err !== 1'b0 || locked !== 1'b1)
      $display("FAIL read_during_lock: got valid=%b auth=%b err=%b locked=%b want 0 0 0 1",
               data_valid, auth_fail, op_err, locked);
    else passes++;
    for (int k = 2; k <= 15; k++) begin
      drive(1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
      if (locked !== 1'b1) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) $display("FAIL lock_hold: got early unlock want locked through cycle 15");
    else passes++;
    // Edge 16 still samples in lockout; locked falls on it
    drive(1'b0, 1'b1, 8'hBF, 4'd2, 8'h00);
    checks++;
    if (locked !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL lock_release: got locked=%b valid=%b want 0 0", locked, data_valid);
    else passes++;
    rd_push(4'd2, 8'hBF, 8'hBB);
    drop_missing("first_read_after_lock");
  endtask

  task automatic test_fail_clear();
    bit no_lock = 1'b1;
    drive(1'b1, 1'b0, 8'h11, 4'd1, 8'h00);
    drive(1'b0, 1'b1, 8'h22, 4'd1, 8'h00);
    rd_push(4'd2, 8'hBF, 8'hBB);
    drop_missing("clear_read");
    drive(1'b1, 1'b0, 8'h33, 4'd1, 8'h00);
    if (locked !== 1'b0) no_lock = 1'b0;
    drive(1'b0, 1'b1, 8'h44, 4'd10, 8'h00);
    checks++;
    if (!no_lock || locked !== 1'b0 || auth_fail !== 1'b1)
      $display("FAIL fail_counter_clear: got locked=%b auth=%b want 0 1", locked, auth_fail);
    else passes++;
    rd_push(4'd9, 8'h3E, 8'hCC);
    drop_missing("clear_read_2");
  endtask

  task automatic test_op_err_and_reset();
    drive(1'b1, 1'b1, 8'hBF, 4'd2, 8'h11);
    checks++;
    if (op_err !== 1'b1 || data_valid !== 1'b0 || auth_fail !== 1'b0)
      $display("FAIL both_enables: got err=%b valid=%b auth=%b want 1 0 0",
               op_err, data_valid, auth_fail);
    else passes++;
    rd_push(4'd2, 8'hBF, 8'hBB);
    drop_missing("after_both_enables");
    // Two wrong plus both-enable with wrong pw: op_err must not count as a failure
    drive(1'b1, 1'b0, 8'h00, 4'd3, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 4'd3, 8'h00);
    drive(1'b1, 1'b1, 8'h00, 4'd3, 8'h00);
    checks++;
    if (op_err !== 1'b1 || auth_fail !== 1'b0 || locked !== 1'b0)
      $display("FAIL both_enables_no_count: got err=%b auth=%b locked=%b want 1 0 0",
               op_err, auth_fail, locked);
    else passes++;
    drive(1'b1, 1'b0, 8'h00, 4'd3, 8'h00);
    checks++;
    if (locked !== 1'b1) $display("FAIL third_fail_locks: got %b want 1", locked);
    else passes++;
    drive(1'b0, 1'b0, 8'h00, 4'd0, 8'h00);
    rst = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || data_output !== 8'h00)
      $display("FAIL async_reset: got locked=%b data=%h want 0 00", locked, data_output);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_push(4'd2, 8'hBF, 8'h00);
    drop_missing("ram_cleared");
    rd_push(4'd9, 8'h3E, 8'h00);
    drop_missing("rom_cleared");
    drive(1'b1, 1'b0, 8'h3E, 4'd9, 8'hAA);
    checks++;
    if (op_err !== 1'b0) $display("FAIL rom_reprogram: got op_err=%b want 0", op_err);
    else passes++;
    rd_push(4'd9, 8'h3E, 8'hAA);
    drop_missing("rom_reprogram_read");
  endtask

  initial begin
    test_reset();
    test_auth_fail();
    test_ram_rw();
    test_rom();
    test_lockout();
    test_fail_clear();
    test_op_err_and_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
